// File: rtl/cdc_4phase_src_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_4phase_src_arb_if
//  Description : Bundle of the requester-side and channel-side handshake
//                signals of the source-domain CDC arbiter.
//                Member names are given from the arbiter's point of view
//                (_i = into the arbiter, _o = out of the arbiter).
//  Ports       : none (pure signal bundle)
//    slave  modport : arbiter view (takes requests, drives the channel)
//    master modport : environment view (requesters + channel src side)
//  Revision    : 1.0  initial release
// ============================================================================
interface cdc_4phase_src_arb_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ*DW-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [N_REQ-1:0]    en_i;
  logic                cdc_valid_o;
  logic [IDW+DW-1:0]   cdc_data_o;
  logic                cdc_ready_i;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    output req_ready_o,
    input  en_i,
    output cdc_valid_o,
    output cdc_data_o,
    input  cdc_ready_i
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    input  req_ready_o,
    output en_i,
    input  cdc_valid_o,
    input  cdc_data_o,
    output cdc_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/cdc_4phase_src_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_4phase_src_arb
//  Description : Round-robin arbiter sharing one 4-phase CDC channel between
//                N_REQ source-domain requesters. The granted payload is
//                registered, tagged {index, payload} and held on the channel
//                src valid/ready interface until accepted. A sticky stall
//                watchdog flags a channel that stops accepting.
//  Ports       :
//    src_clk_i   in   source-domain clock
//    src_rst_ni  in   asynchronous active-low reset
//    bus         slave modport of cdc_4phase_src_arb_if
//                  req_valid_i / req_data_i / req_ready_o / en_i (requesters)
//                  cdc_valid_o / cdc_data_o / cdc_ready_i (channel src side)
//    busy_o      out  output register occupied (== cdc_valid_o)
//    timeout_o   out  sticky stall flag
//    clr_i       in   synchronous clear of timeout_o and the stall counter
//  Revision    : 1.0  initial release
// ============================================================================
module cdc_4phase_src_arb #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  wire logic               src_clk_i,
  input  wire logic               src_rst_ni,
  cdc_4phase_src_arb_if.slave     bus,
  output logic                    busy_o,
  output logic                    timeout_o,
  input  wire logic               clr_i
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               r_valid;
  logic [IDW+DW-1:0]  r_data;
  logic [IDW-1:0]     r_last;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0]   w_elig;
  logic               w_free;
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW:0]       w_cand;
  logic               w_grant;
  logic [DW-1:0]      w_req_data [N_REQ];

  assign w_elig  = bus.req_valid_i & bus.en_i;
  // The slot can take a new word when empty or when the held word leaves now.
  assign w_free  = ~r_valid | bus.cdc_ready_i;
  assign w_grant = w_free & w_found;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_req_data[k] = bus.req_data_i[k*DW +: DW];
  end

  // Search from last+1 upward, wrapping modulo N_REQ; the first hit wins.
  // The candidate is one bit wider than an index so last+offset cannot
  // overflow before the wrap subtraction.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = {1'b0, r_last} + (IDW+1)'(off);
      if (w_cand >= (IDW+1)'(N_REQ)) begin
        w_cand = w_cand - (IDW+1)'(N_REQ);
      end
      if (!w_found && w_elig[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[IDW-1:0];
      end
    end
  end

  assign bus.req_ready_o = w_grant ? (N_REQ'(1) << w_win) : '0;

  // --------------------------------------------------------------------------
  // Output register: capture on grant, hold while stalled, empty after a
  // handshake with nothing to replace it.
  // --------------------------------------------------------------------------
  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= IDW'(N_REQ - 1);
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_data  <= {w_win, w_req_data[w_win]};
      r_last  <= w_win;
    end else if (bus.cdc_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.cdc_valid_o = r_valid;
  assign bus.cdc_data_o  = r_data;
  assign busy_o          = r_valid;

  // --------------------------------------------------------------------------
  // Stall watchdog
  // --------------------------------------------------------------------------
  if (TIMEOUT != 0) begin : g_wdog
    localparam logic [CW-1:0] c_limit = CW'(TIMEOUT);

    logic [CW-1:0] r_stall_cnt;
    logic          r_timeout;
    logic          w_stall;

    assign w_stall = r_valid & ~bus.cdc_ready_i;

    // clr_i has priority so a clear coinciding with the limit still clears.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
        r_stall_cnt <= '0;
        r_timeout   <= 1'b0;
      end else if (clr_i) begin
        r_stall_cnt <= '0;
        r_timeout   <= 1'b0;
      end else if (w_stall) begin
        if (r_stall_cnt != c_limit) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
        // Set on the edge where the count becomes (or already is) the limit.
        if (r_stall_cnt >= c_limit - 1'b1) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end

    assign timeout_o = r_timeout;
  end else begin : g_no_wdog
    logic w_unused;
    assign w_unused  = clr_i;
    assign timeout_o = 1'b0;
  end

endmodule
`default_nettype wire
